// File: rtl/aibcr3_latch_wr_ctrl.sv
// Write-side sequencer for a bank of resettable configuration latches.
// Sequences setup / enable-pulse / hold for single-word writes and a pulsed bank clear.
module aibcr3_latch_wr_ctrl #(
    parameter int NUM_LATCH = 16,
    parameter int DW        = 8,
    parameter int AW        = 4,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    output logic                 wr_ready,
    input  logic                 clr_req,
    output logic                 wr_done,
    output logic                 wr_err,
    output logic                 busy,
    output logic [DW-1:0]        lat_d,
    output logic [NUM_LATCH-1:0] lat_e,
    output logic                 lat_cdn
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_CLR,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          err;
    } req_t;

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    req_t                 req_q, req_d;
    logic [DW-1:0]        lat_d_q, lat_d_d;
    logic [NUM_LATCH-1:0] lat_e_q, lat_e_d;
    logic                 lat_cdn_q, lat_cdn_d;
    logic                 wr_ready_q, wr_ready_d;
    logic                 wr_done_q, wr_done_d;
    logic                 wr_err_q, wr_err_d;
    logic                 busy_q, busy_d;
    logic                 addr_in_range;
    logic [NUM_LATCH-1:0] addr_dec;

    // Extra bit keeps the compare correct when NUM_LATCH == 2**AW.
    assign addr_in_range = ({1'b0, wr_addr} < (AW+1)'(NUM_LATCH));

    for (genvar i = 0; i < NUM_LATCH; i++) begin : g_dec
        assign addr_dec[i] = (req_q.addr == AW'(i));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        lat_d_d = lat_d_q;
        case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLR;
                    cnt_d   = PULSE_LD;
                end else if (wr_valid) begin
                    state_d    = ST_SETUP;
                    cnt_d      = SETUP_LD;
                    req_d.addr = wr_addr;
                    req_d.err  = ~addr_in_range;
                    lat_d_d    = wr_data;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    if (req_q.err) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_PULSE;
                        cnt_d   = PULSE_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD, ST_CLR: begin
                if (cnt_q == 4'd0) state_d = ST_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase
    end

    // Outputs are registered from the next state so each phase's levels align with the phase itself.
    always_comb begin
        lat_e_d    = (state_d == ST_PULSE) ? addr_dec : '0;
        lat_cdn_d  = (state_d != ST_CLR);
        wr_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
        wr_done_d  = (state_q == ST_DONE);
        wr_err_d   = (state_q == ST_DONE) && req_q.err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= 4'd0;
            req_q      <= '0;
            lat_d_q    <= '0;
            lat_e_q    <= '0;
            lat_cdn_q  <= 1'b0;
            wr_ready_q <= 1'b0;
            wr_done_q  <= 1'b0;
            wr_err_q   <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            lat_d_q    <= lat_d_d;
            lat_e_q    <= lat_e_d;
            lat_cdn_q  <= lat_cdn_d;
            wr_ready_q <= wr_ready_d;
            wr_done_q  <= wr_done_d;
            wr_err_q   <= wr_err_d;
            busy_q     <= busy_d;
        end
    end

    assign lat_d    = lat_d_q;
    assign lat_e    = lat_e_q;
    assign lat_cdn  = lat_cdn_q;
    assign wr_ready = wr_ready_q;
    assign wr_done  = wr_done_q;
    assign wr_err   = wr_err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_aibcr3_latch_wr_ctrl.sv
// Directed bench for aibcr3_latch_wr_ctrl: default, short-bank and 1/4/3-timing instances.
module tb_aibcr3_latch_wr_ctrl;

    logic clk;
    logic rst_n;
    int   nvec;
    int   nerr;

    // instance 0: defaults
    logic        v0, r0, c0, d0, e0, b0, cdn0;
    logic [3:0]  a0;
    logic [7:0]  w0, ld0;
    logic [15:0] le0;
    // instance 1: NUM_LATCH=12
    logic        v1, r1, c1, d1, e1, b1, cdn1;
    logic [3:0]  a1;
    logic [7:0]  w1, ld1;
    logic [11:0] le1;
    // instance 2: SETUP=1 PULSE=4 HOLD=3
    logic        v2, r2, c2, d2, e2, b2, cdn2;
    logic [3:0]  a2;
    logic [7:0]  w2, ld2;
    logic [15:0] le2;

    logic [7:0]  model [16];
    logic [7:0]  cap   [16];

    aibcr3_latch_wr_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .wr_valid(v0), .wr_addr(a0), .wr_data(w0),
        .wr_ready(r0), .clr_req(c0), .wr_done(d0), .wr_err(e0), .busy(b0),
        .lat_d(ld0), .lat_e(le0), .lat_cdn(cdn0)
    );

    aibcr3_latch_wr_ctrl #(.NUM_LATCH(12)) u1 (
        .clk(clk), .rst_n(rst_n), .wr_valid(v1), .wr_addr(a1), .wr_data(w1),
        .wr_ready(r1), .clr_req(c1), .wr_done(d1), .wr_err(e1), .busy(b1),
        .lat_d(ld1), .lat_e(le1), .lat_cdn(cdn1)
    );

    aibcr3_latch_wr_ctrl #(.SETUP_CYC(1), .PULSE_CYC(4), .HOLD_CYC(3)) u2 (
        .clk(clk), .rst_n(rst_n), .wr_valid(v2), .wr_addr(a2), .wr_data(w2),
        .wr_ready(r2), .clr_req(c2), .wr_done(d2), .wr_err(e2), .busy(b2),
        .lat_d(ld2), .lat_e(le2), .lat_cdn(cdn2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] oh;
        logic [3:0]  ta;
        logic [7:0]  td;
        nvec  = 0;
        nerr  = 0;
        rst_n = 1'b0;
        v0 = 0; a0 = 0; w0 = 0; c0 = 0;
        v1 = 0; a1 = 0; w1 = 0; c1 = 0;
        v2 = 0; a2 = 0; w2 = 0; c2 = 0;
        for (int i = 0; i < 16; i++) begin
            model[i] = 8'h00;
            cap[i]   = 8'h00;
        end

        // 1: reset state and INIT release
        tick; tick;
        check("rst_cdn", cdn0, 0);
        check("rst_ready", r0, 0);
        check("rst_busy", b0, 1);
        check("rst_lat_e", le0, 0);
        check("rst_lat_d", ld0, 0);
        check("rst_done", d0, 0);
        rst_n = 1'b1;
        check("init_cdn_hold", cdn0, 0);
        tick;
        check("init_cdn", cdn0, 1);
        check("init_ready", r0, 1);
        check("init_busy", b0, 0);
        check("init_lat_e", le0, 0);

        // 2: default write addr=5 data=A5
        v0 = 1; a0 = 4'd5; w0 = 8'hA5;
        tick;
        v0 = 0;
        check("w5_lat_d", ld0, 8'hA5);
        check("w5_ready_drop", r0, 0);
        check("w5_busy", b0, 1);
        check("w5_lat_e0", le0, 0);
        for (int k = 1; k <= 8; k++) begin
            tick;
            check($sformatf("w5_lat_e_k%0d", k), le0, (k == 2 || k == 3) ? 32'h20 : 32'h0);
            check($sformatf("w5_done_k%0d", k), d0, (k == 7) ? 1 : 0);
            check($sformatf("w5_ready_k%0d", k), r0, (k >= 7) ? 1 : 0);
            check($sformatf("w5_lat_d_k%0d", k), ld0, 8'hA5);
        end
        check("w5_err", e0, 0);

        // 3: out-of-range on 12-latch bank
        v1 = 1; a1 = 4'd13; w1 = 8'h3C;
        tick;
        v1 = 0;
        for (int k = 1; k <= 4; k++) begin
            tick;
            check($sformatf("oor_lat_e_k%0d", k), le1, 0);
            check($sformatf("oor_done_k%0d", k), d1, (k == 3) ? 1 : 0);
            check($sformatf("oor_err_k%0d", k), e1, (k == 3) ? 1 : 0);
        end

        // 4: clear wins over a concurrent write, write is taken afterwards
        c0 = 1; v0 = 1; a0 = 4'd9; w0 = 8'h5A;
        tick;
        c0 = 0;
        check("clr_ready", r0, 0);
        check("clr_cdn0", cdn0, 0);
        check("clr_lat_d_kept", ld0, 8'hA5);
        tick;
        check("clr_cdn1", cdn0, 0);
        check("clr_lat_e", le0, 0);
        tick;
        check("clr_cdn2", cdn0, 1);
        check("clr_done2", d0, 0);
        tick;
        check("clr_done3", d0, 1);
        check("clr_err3", e0, 0);
        check("clr_ready3", r0, 1);
        tick;
        v0 = 0;
        check("held_lat_d", ld0, 8'h5A);
        for (int k = 1; k <= 7; k++) begin
            tick;
            check($sformatf("held_lat_e_k%0d", k), le0, (k == 2 || k == 3) ? 32'h200 : 32'h0);
            check($sformatf("held_done_k%0d", k), d0, (k == 7) ? 1 : 0);
        end

        // 5: reset during PULSE of write to addr=3
        v0 = 1; a0 = 4'd3; w0 = 8'h77;
        tick;
        v0 = 0;
        tick; tick;
        check("rmid_lat_e_pre", le0, 32'h8);
        #2 rst_n = 1'b0;
        #1;
        check("rmid_lat_e", le0, 0);
        check("rmid_cdn", cdn0, 0);
        check("rmid_busy", b0, 1);
        check("rmid_ready", r0, 0);
        tick;
        check("rmid_done_a", d0, 0);
        tick;
        rst_n = 1'b1;
        check("rmid_cdn_hold", cdn0, 0);
        tick;
        check("rmid_init_cdn", cdn0, 1);
        check("rmid_init_ready", r0, 1);
        check("rmid_init_busy", b0, 0);
        check("rmid_done_b", d0, 0);
        for (int k = 0; k < 8; k++) begin
            tick;
            check($sformatf("rmid_no_done_k%0d", k), d0, 0);
        end

        // 6: back-to-back random writes on 1/4/3 timing with scoreboard
        for (int n = 0; n < 20; n++) begin
            ta = 4'($urandom_range(0, 15));
            td = 8'($urandom_range(0, 255));
            oh = 16'h1 << ta;
            model[ta] = td;
            check($sformatf("b2b%0d_ready", n), r2, 1);
            v2 = 1; a2 = ta; w2 = td;
            tick;
            v2 = 0;
            check($sformatf("b2b%0d_lat_d0", n), ld2, td);
            check($sformatf("b2b%0d_lat_e0", n), le2, 0);
            for (int k = 1; k <= 9; k++) begin
                tick;
                for (int i = 0; i < 16; i++)
                    if (le2[i]) cap[i] = ld2;
                check($sformatf("b2b%0d_lat_e_k%0d", n, k), le2, (k >= 1 && k <= 4) ? oh : 16'h0);
                check($sformatf("b2b%0d_lat_d_k%0d", n, k), ld2, td);
                check($sformatf("b2b%0d_done_k%0d", n, k), d2, (k == 9) ? 1 : 0);
            end
        end
        for (int i = 0; i < 16; i++)
            check($sformatf("sb_word%0d", i), cap[i], model[i]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
